// File: rtl/icache_ctrl_pkg.sv
// Shared types and defaults for the instruction-cache control blocks.
package icache_ctrl_pkg;

  localparam int DEFAULT_NUM_LINES = 256;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FLUSH = 2'd1,
    DONE  = 2'd2
  } flush_state_e;

endpackage : icache_ctrl_pkg

// File: rtl/icache_flush_walker.sv
// Tag-line walk counter: restarts at 0 on start, advances on enable, wraps naturally.
module icache_flush_walker #(
  parameter int NUM_LINES = 256,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start,
  input  logic             enable,
  output logic [IDX_W-1:0] idx,
  output logic             last
);

  logic [IDX_W-1:0] idx_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      idx_q <= '0;
    end else if (start) begin
      idx_q <= '0;
    end else if (enable) begin
      idx_q <= idx_q + 1'b1;
    end
  end

  assign idx  = idx_q;
  assign last = (idx_q == IDX_W'(NUM_LINES - 1));

endmodule : icache_flush_walker

// File: rtl/icache_flush_ctrl.sv
// Instruction-cache flush controller: whole-array valid-bit walk for two fetch ports plus single-line invalidates.
module icache_flush_ctrl
  import icache_ctrl_pkg::*;
#(
  parameter int NUM_LINES = DEFAULT_NUM_LINES,
  parameter int IDX_W     = $clog2(NUM_LINES)
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       flush_req_i,
  output logic [1:0]       flush_ack_o,
  input  logic             inv_valid_i,
  input  logic [IDX_W-1:0] inv_idx_i,
  output logic             inv_ready_o,
  output logic             tag_wr_o,
  output logic [IDX_W-1:0] tag_idx_o,
  output logic             lookup_stall_o,
  output logic             busy_o
);

  flush_state_e     state_q;
  logic [1:0]       served_q;
  logic [IDX_W-1:0] walk_idx;
  logic             walk_last;
  logic             walk_start;
  logic             walk_enable;

  assign walk_start  = (state_q == IDLE) && (flush_req_i != 2'b00);
  assign walk_enable = (state_q == FLUSH);

  icache_flush_walker #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) u_walker (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .start  (walk_start),
    .enable (walk_enable),
    .idx    (walk_idx),
    .last   (walk_last)
  );

  // Requesters are only captured in IDLE; late arrivals wait for the next full walk.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      served_q <= 2'b00;
    end else begin
      case (state_q)
        IDLE: begin
          if (flush_req_i != 2'b00) begin
            served_q <= flush_req_i;
            state_q  <= FLUSH;
          end
        end
        FLUSH: begin
          if (walk_last) begin
            state_q <= DONE;
          end
        end
        DONE: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign inv_ready_o = (state_q == IDLE) && (flush_req_i == 2'b00);

  always_comb begin
    tag_wr_o  = 1'b0;
    tag_idx_o = '0;
    if (state_q == FLUSH) begin
      tag_wr_o  = 1'b1;
      tag_idx_o = walk_idx;
    end else if (inv_valid_i && inv_ready_o) begin
      tag_wr_o  = 1'b1;
      tag_idx_o = inv_idx_i;
    end
  end

  assign flush_ack_o    = (state_q == DONE) ? served_q : 2'b00;
  assign lookup_stall_o = (state_q != IDLE);
  assign busy_o         = (state_q != IDLE);

endmodule : icache_flush_ctrl

// File: tb/tb_icache_flush_ctrl.sv
// Self-checking bench: directed flush scenarios plus random traffic against a walk-position reference model.
module tb_icache_flush_ctrl;

  localparam int NUM_LINES = 256;
  localparam int IDX_W     = 8;

  logic             clk_i = 1'b0;
  logic             rst_ni;
  logic [1:0]       flush_req_i;
  logic [1:0]       flush_ack_o;
  logic             inv_valid_i;
  logic [IDX_W-1:0] inv_idx_i;
  logic             inv_ready_o;
  logic             tag_wr_o;
  logic [IDX_W-1:0] tag_idx_o;
  logic             lookup_stall_o;
  logic             busy_o;

  int checks   = 0;
  int failures = 0;

  // Reference model: pos = -1 idle, 0..NUM_LINES-1 walking, NUM_LINES ack cycle.
  int         pos    = -1;
  logic [1:0] served = 2'b00;
  int         cycle_no    = 0;
  int         start_cycle = 0;
  int         ack_cycle   = 0;
  int         wr_count    = 0;
  logic [1:0] last_ack    = 2'b00;

  icache_flush_ctrl #(
    .NUM_LINES (NUM_LINES),
    .IDX_W     (IDX_W)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .flush_req_i    (flush_req_i),
    .flush_ack_o    (flush_ack_o),
    .inv_valid_i    (inv_valid_i),
    .inv_idx_i      (inv_idx_i),
    .inv_ready_o    (inv_ready_o),
    .tag_wr_o       (tag_wr_o),
    .tag_idx_o      (tag_idx_o),
    .lookup_stall_o (lookup_stall_o),
    .busy_o         (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput();
    logic             e_idle, e_walk, e_ready, e_wr;
    logic [IDX_W-1:0] e_idx;
    logic [1:0]       e_ack;
    e_idle  = (pos < 0);
    e_walk  = (pos >= 0) && (pos < NUM_LINES);
    e_ready = e_idle && (flush_req_i == 2'b00);
    e_wr    = e_walk || (e_ready && inv_valid_i);
    e_idx   = e_walk ? IDX_W'(pos) : (e_wr ? inv_idx_i : '0);
    e_ack   = (pos == NUM_LINES) ? served : 2'b00;
    checkVal("inv_ready", 32'(inv_ready_o), 32'(e_ready));
    checkVal("tag_wr", 32'(tag_wr_o), 32'(e_wr));
    checkVal("tag_idx", 32'(tag_idx_o), 32'(e_idx));
    checkVal("flush_ack", 32'(flush_ack_o), 32'(e_ack));
    checkVal("lookup_stall", 32'(lookup_stall_o), 32'(!e_idle));
    checkVal("busy", 32'(busy_o), 32'(!e_idle));
  endtask

  // One clock cycle: raise requests, present invalidate, check, advance model, drop acked requesters.
  task automatic applyStimulus(input logic [1:0] raise, input logic inv_v, input logic [IDX_W-1:0] inv_i);
    logic [1:0] acked;
    flush_req_i = flush_req_i | raise;
    inv_valid_i = inv_v;
    inv_idx_i   = inv_i;
    #1;
    checkOutput();
    if (flush_ack_o != 2'b00) begin
      ack_cycle = cycle_no;
      last_ack  = flush_ack_o;
    end
    if (busy_o && tag_wr_o) wr_count++;
    acked = (pos == NUM_LINES) ? served : 2'b00;
    @(posedge clk_i);
    cycle_no++;
    if (pos < 0) begin
      if (flush_req_i != 2'b00) begin
        served      = flush_req_i;
        pos         = 0;
        start_cycle = cycle_no;
        wr_count    = 0;
      end
    end else if (pos < NUM_LINES) begin
      pos++;
    end else begin
      pos = -1;
    end
    #1;
    flush_req_i = flush_req_i & ~acked;
  endtask

  // Runs idle cycles until an ack is seen, bounded.
  task automatic runFlush(input string tag);
    bit got_ack = 0;
    last_ack = 2'b00;
    for (int i = 0; i < 3 * NUM_LINES; i++) begin
      applyStimulus(2'b00, 1'b0, '0);
      if (last_ack != 2'b00) begin
        got_ack = 1;
        break;
      end
    end
    if (!got_ack) begin
      failures++;
      $display("[TB] FAIL %s_timeout observed=no_ack expected=ack", tag);
    end
  endtask

  task automatic stepUntilPos(input int target);
    for (int i = 0; i < 3 * NUM_LINES && pos != target; i++) applyStimulus(2'b00, 1'b0, '0);
    checkVal("reach_pos", 32'(pos), 32'(target));
  endtask

  initial begin
    rst_ni      = 1'b0;
    flush_req_i = 2'b00;
    inv_valid_i = 1'b0;
    inv_idx_i   = '0;
    #2;
    checkOutput();
    checkVal("rst_ready", 32'(inv_ready_o), 32'd1);
    @(posedge clk_i); #1;
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    $display("[TB] reset released");

    applyStimulus(2'b00, 1'b0, '0);
    applyStimulus(2'b00, 1'b1, 8'h3C);
    checkVal("inv_wr_idle", 32'(tag_idx_o), 32'h3C);
    applyStimulus(2'b01, 1'b1, 8'h3C);
    checkVal("inv_blocked_ready", 32'(inv_ready_o), 32'd0);
    inv_valid_i = 1'b0;

    runFlush("single");
    checkVal("single_ack", 32'(last_ack), 32'h1);
    checkVal("single_latency", 32'(ack_cycle - start_cycle), 32'(NUM_LINES));
    checkVal("single_writes", 32'(wr_count), 32'(NUM_LINES));
    applyStimulus(2'b00, 1'b0, '0);
    checkVal("idle_after_ack", 32'(busy_o), 32'd0);

    applyStimulus(2'b11, 1'b0, '0);
    runFlush("merged");
    checkVal("merged_ack", 32'(last_ack), 32'h3);
    checkVal("merged_writes", 32'(wr_count), 32'(NUM_LINES));

    applyStimulus(2'b01, 1'b0, '0);
    stepUntilPos(100);
    applyStimulus(2'b10, 1'b0, '0);
    runFlush("late_first");
    checkVal("late_first_ack", 32'(last_ack), 32'h1);
    runFlush("late_second");
    checkVal("late_second_ack", 32'(last_ack), 32'h2);
    checkVal("late_second_writes", 32'(wr_count), 32'(NUM_LINES));

    applyStimulus(2'b01, 1'b0, '0);
    stepUntilPos(50);
    rst_ni = 1'b0;
    pos    = -1;
    served = 2'b00;
    #1;
    checkOutput();
    checkVal("rst_mid_wr", 32'(tag_wr_o), 32'd0);
    checkVal("rst_mid_ack", 32'(flush_ack_o), 32'd0);
    @(posedge clk_i); #1;
    rst_ni = 1'b1;
    runFlush("post_reset");
    checkVal("post_reset_ack", 32'(last_ack), 32'h1);
    checkVal("post_reset_writes", 32'(wr_count), 32'(NUM_LINES));

    for (int i = 0; i < 4000; i++) begin
      logic [1:0] r;
      r = ($urandom_range(0, 40) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      applyStimulus(r, 1'($urandom_range(0, 1)), IDX_W'($urandom));
    end
    inv_valid_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule : tb_icache_flush_ctrl
